// File: rtl/pow2_mlp_pkg.sv
// Shared types and helpers for the sequential power-of-two MLP: weight-code
// layout {nz, neg, exp}, code decode, FSM state encoding and quantised ReLU.
package pow2_mlp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HID,
    ST_OUT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       nz;
    logic       neg;
    logic [7:0] exp;
  } wfield_t;

  localparam int DEF_EXP_W = 3;
  localparam int DEF_CW    = DEF_EXP_W + 2;

  // Encodes a signed power-of-two weight (or zero) into a default-width code.
  function automatic logic [DEF_CW-1:0] wenc(input int w);
    int                   a;
    logic [DEF_EXP_W-1:0] e;
    a = (w < 0) ? -w : w;
    e = '0;
    for (int b = 0; b < (1 << DEF_EXP_W); b++) begin
      if (a == (1 << b)) e = DEF_EXP_W'(b);
    end
    return (w == 0) ? '0 : {1'b1, (w < 0), e};
  endfunction

  function automatic wfield_t wdecode(input logic [31:0] code, input int exp_w);
    wfield_t f;
    f.exp = 8'(code & ((32'd1 << exp_w) - 32'd1));
    f.neg = code[exp_w];
    f.nz  = code[exp_w+1];
    return f;
  endfunction

  // Clamp negative sums to zero, saturate above the activation range, else truncate.
  function automatic logic [31:0] qrelu(input logic signed [63:0] a,
                                        input int qshift, input int in_w);
    logic signed [63:0] sh;
    logic signed [63:0] maxv;
    sh   = a >>> qshift;
    maxv = (64'sd1 <<< in_w) - 64'sd1;
    if (a < 0) return '0;
    if (sh > maxv) return 32'(maxv);
    return 32'(sh);
  endfunction

endpackage

// File: rtl/pow2_shift_mac.sv
// Combinational shift-add step: acc_n = (first ? bias : acc) +/- (operand << exp),
// shared by hidden and output layers.
module pow2_shift_mac
  import pow2_mlp_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int EXP_W = 3,
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] bias,
  input  logic [IN_W-1:0]         operand,
  input  logic [EXP_W+1:0]        code,
  input  logic                    first,
  output logic signed [ACC_W-1:0] acc_n
);

  wfield_t                 wf;
  logic [ACC_W-1:0]        term;
  logic signed [ACC_W-1:0] base;

  always_comb begin
    wf   = wdecode(32'(code), EXP_W);
    term = ACC_W'(operand) << wf.exp;
    base = first ? bias : acc;
    if (!wf.nz)
      acc_n = base;
    else if (wf.neg)
      acc_n = base - term;
    else
      acc_n = base + term;
  end

endmodule

// File: rtl/pow2_mlp_seq.sv
// Sequential two-layer power-of-two MLP classifier, one shift-add MAC per cycle.
// Define PMLP_SCORES_EN to expose the raw output-neuron sums on out_scores.
module pow2_mlp_seq
  import pow2_mlp_pkg::*;
#(
  parameter int N_IN   = 6,
  parameter int N_HID  = 3,
  parameter int N_OUT  = 3,
  parameter int IN_W   = 4,
  parameter int EXP_W  = 3,
  parameter int ACC_W  = 16,
  parameter int QSHIFT = 6,
  parameter logic [N_HID*N_IN*(EXP_W+2)-1:0] W0 = {
    wenc(128), wenc(64), wenc(64), wenc(32), wenc(-32), wenc(32),
    wenc(-128), wenc(64), wenc(32), wenc(16), wenc(-32), wenc(16),
    wenc(0), wenc(4), wenc(0), wenc(0), wenc(4), wenc(-8)
  },
  parameter logic [N_OUT*N_HID*(EXP_W+2)-1:0] W1 = {
    wenc(-8), wenc(16), wenc(2),
    wenc(16), wenc(-16), wenc(-2),
    wenc(-16), wenc(8), wenc(0)
  },
  parameter logic [N_HID*ACC_W-1:0] B0 = {ACC_W'(-256), ACC_W'(128), ACC_W'(-128)},
  parameter logic [N_OUT*ACC_W-1:0] B1 = {ACC_W'(-64), ACC_W'(32), ACC_W'(32)}
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [N_IN*IN_W-1:0]                     inp,
  output logic                                     out_valid,
  input  logic                                     out_ready,
`ifdef PMLP_SCORES_EN
  output logic [N_OUT*ACC_W-1:0]                   out_scores,
`endif
  output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] out
);

  localparam int CW    = EXP_W + 2;
  localparam int OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int MAXN  = (N_IN > N_HID) ? ((N_IN > N_OUT) ? N_IN : N_OUT)
                                        : ((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int CNT_W = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] LAST_HID = CNT_W'(N_HID - 1);
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(N_OUT - 1);

  state_t                  state_reg;
  logic [CNT_W-1:0]        i_reg, j_reg;
  logic [N_IN*IN_W-1:0]    x_reg;
  logic [N_HID*IN_W-1:0]   h_flat;
  logic signed [ACC_W-1:0] acc_reg, best_reg;
  logic [OUT_W-1:0]        best_idx_reg, out_reg;
  logic                    out_valid_reg;

  logic                    in_hid, first, last_term, new_best;
  logic [IN_W-1:0]         operand, h_op, h_new;
  logic [CW-1:0]           code;
  logic signed [ACC_W-1:0] bias, acc_n;
  int                      w0_idx, w1_idx;

  always_comb begin
    in_hid = (state_reg == ST_HID);
    first  = (i_reg == '0);
    w0_idx = int'(j_reg) * N_IN + int'(i_reg);
    w1_idx = int'(j_reg) * N_HID + int'(i_reg);
    h_op   = '0;
    for (int k = 0; k < N_HID; k++) begin
      if (i_reg == CNT_W'(k)) h_op = h_flat[IN_W*k +: IN_W];
    end
    if (in_hid) begin
      operand = x_reg[IN_W*int'(i_reg) +: IN_W];
      code    = W0[CW*w0_idx +: CW];
      bias    = B0[ACC_W*int'(j_reg) +: ACC_W];
    end else begin
      operand = h_op;
      code    = W1[CW*w1_idx +: CW];
      bias    = B1[ACC_W*int'(j_reg) +: ACC_W];
    end
    last_term = in_hid ? (i_reg == LAST_IN) : (i_reg == LAST_HID);
    new_best  = (j_reg == '0) || (acc_n > best_reg);
    h_new     = IN_W'(qrelu(64'(acc_n), QSHIFT, IN_W));
  end

  pow2_shift_mac #(
    .IN_W (IN_W),
    .EXP_W(EXP_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .acc    (acc_reg),
    .bias   (bias),
    .operand(operand),
    .code   (code),
    .first  (first),
    .acc_n  (acc_n)
  );

  // Each hidden activation is its own register, written when its neuron's last term lands.
  for (genvar gi = 0; gi < N_HID; gi++) begin : g_hid
    logic [IN_W-1:0] h_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        h_q <= '0;
      else if (in_hid && last_term && j_reg == CNT_W'(gi))
        h_q <= h_new;
    end
    assign h_flat[IN_W*gi +: IN_W] = h_q;
  end

`ifdef PMLP_SCORES_EN
  logic [N_OUT*ACC_W-1:0] scores_flat;
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_score
    logic [ACC_W-1:0] sc_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        sc_q <= '0;
      else if (state_reg == ST_OUT && last_term && j_reg == CNT_W'(gi))
        sc_q <= acc_n;
    end
    assign scores_flat[ACC_W*gi +: ACC_W] = sc_q;
  end
  assign out_scores = scores_flat;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      i_reg         <= '0;
      j_reg         <= '0;
      x_reg         <= '0;
      acc_reg       <= '0;
      best_reg      <= '0;
      best_idx_reg  <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg     <= inp;
            i_reg     <= '0;
            j_reg     <= '0;
            state_reg <= ST_HID;
          end
        end
        ST_HID: begin
          acc_reg <= acc_n;
          if (last_term) begin
            i_reg <= '0;
            if (j_reg == LAST_HID) begin
              j_reg     <= '0;
              state_reg <= ST_OUT;
            end else begin
              j_reg <= j_reg + 1'b1;
            end
          end else begin
            i_reg <= i_reg + 1'b1;
          end
        end
        ST_OUT: begin
          acc_reg <= acc_n;
          if (last_term) begin
            i_reg <= '0;
            if (new_best) begin
              best_reg     <= acc_n;
              best_idx_reg <= OUT_W'(j_reg);
            end
            if (j_reg == LAST_OUT) begin
              // The final neuron's comparison is folded straight into the result.
              out_reg       <= new_best ? OUT_W'(j_reg) : best_idx_reg;
              out_valid_reg <= 1'b1;
              j_reg         <= '0;
              state_reg     <= ST_DONE;
            end else begin
              j_reg <= j_reg + 1'b1;
            end
          end else begin
            i_reg <= i_reg + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = out_valid_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_pow2_mlp_seq.sv
// Directed self-checking bench for pow2_mlp_seq with default weights.
module tb_pow2_mlp_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] inp = '0;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out;
`ifdef PMLP_SCORES_EN
  logic [47:0] out_scores;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pow2_mlp_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PMLP_SCORES_EN
    .out_scores(out_scores),
`endif
    .out       (out)
  );

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  // Accepts one vector, checks latency/class, then completes the handshake.
  task automatic test_vector(input string name, input logic [23:0] v,
                             input logic [1:0] exp_out, input logic [47:0] exp_sc);
    int cnt;
    in_valid = 1'b1;
    inp      = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inp      = 24'hA5A5A5;
    wait_out(cnt);
    checks++;
    if (cnt !== 27) $display("FAIL %s latency: got %0d cycles, expected 27", name, cnt);
    else passes++;
    checks++;
    if (out !== exp_out) $display("FAIL %s class: got %0d, expected %0d", name, out, exp_out);
    else passes++;
`ifdef PMLP_SCORES_EN
    checks++;
    if (out_scores !== exp_sc) $display("FAIL %s scores: got %h, expected %h", name, out_scores, exp_sc);
    else passes++;
`else
    if (exp_sc === 48'hx) $display("note: %s has no expected scores", name);
`endif
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s handshake: got out_valid=%b in_ready=%b, expected 0 1", name, out_valid, in_ready);
    else passes++;
    $display("vector %s: class %0d after %0d cycles", name, out, cnt);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b, expected 0", out_valid);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b, expected 1", in_ready);
    else passes++;
    checks++;
    if (out !== 2'd0) $display("FAIL reset out: got %0d, expected 0", out);
    else passes++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("reset released");
  endtask

  task automatic test_backpressure();
    int cnt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inp       = 24'h0F0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(cnt);
    checks++;
    if (cnt !== 27 || out !== 2'd2)
      $display("FAIL bp result: got class %0d after %0d, expected 2 after 27", out, cnt);
    else passes++;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      inp      = 24'hFFFFFF;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out !== 2'd2 || in_ready !== 1'b0)
        $display("FAIL bp hold cycle %0d: got v=%b out=%0d rdy=%b, expected 1 2 0",
                 c, out_valid, out, in_ready);
      else passes++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp release: got v=%b rdy=%b, expected 0 1", out_valid, in_ready);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL bp idle after release: got rdy=%b, expected 1", in_ready);
    else passes++;
    $display("backpressure: held 10 cycles, released");
  endtask

  task automatic test_reset_mid();
    int stale;
    in_valid = 1'b1;
    inp      = 24'hFFFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midreset immediate: got v=%b rdy=%b, expected 0 1", out_valid, in_ready);
    else passes++;
    #1;
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) stale++;
    end
    checks++;
    if (stale !== 0) $display("FAIL midreset stale: got %0d valid cycles, expected 0", stale);
    else passes++;
    $display("mid-computation reset applied");
    test_vector("after_reset_zero", 24'h000000, 2'd0, {16'hFFE0, 16'h0000, 16'h0030});
  endtask

  task automatic test_back_to_back();
    int cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inp       = 24'h000000;
    @(posedge clk);
    #1;
    inp = 24'hFFFFFF;
    wait_out(cnt);
    checks++;
    if (cnt !== 27 || out !== 2'd0)
      $display("FAIL b2b first: got class %0d after %0d, expected 0 after 27", out, cnt);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL b2b idle: got rdy=%b v=%b, expected 1 0", in_ready, out_valid);
    else passes++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b second accept: got rdy=%b, expected 0", in_ready);
    else passes++;
    wait_out(cnt);
    checks++;
    if (cnt !== 27 || out !== 2'd1)
      $display("FAIL b2b second: got class %0d after %0d, expected 1 after 27", out, cnt);
    else passes++;
    @(posedge clk);
    #1;
    $display("back-to-back: two vectors completed");
  endtask

  initial begin
    test_reset();
    test_vector("all_zero", 24'h000000, 2'd0, {16'hFFE0, 16'h0000, 16'h0030});
    test_vector("all_15", 24'hFFFFFF, 2'd1, {16'hFF48, 16'h0110, 16'hFF30});
    test_vector("in4_15", 24'h0F0000, 2'd2, {16'h0058, 16'hFFE0, 16'hFFE8});
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
